// File: rtl/master_port_burst.sv
// Serial-bus master port: burst commands become per-beat serial transactions
// (device address, ack, memory address, data) while holding bus ownership.
module master_port_burst #(
    parameter int ADDR_WIDTH           = 16,
    parameter int DATA_WIDTH           = 8,
    parameter int SLAVE_MEM_ADDR_WIDTH = 12,
    parameter int LANE_WIDTH           = 1,
    parameter int MAX_BURST            = 8,
    parameter int TIMEOUT              = 5,
    parameter int MAX_RETRY            = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         dvalid,
    output logic                         dready,
    input  logic [ADDR_WIDTH-1:0]        daddr,
    input  logic                         dmode,
    input  logic [$clog2(MAX_BURST):0]   dlen,
    input  logic [DATA_WIDTH-1:0]        dwdata,
    input  logic                         dwvalid,
    output logic                         dwready,
    input  logic [DATA_WIDTH-1:0]        dwnext,
    output logic [DATA_WIDTH-1:0]        drdata,
    output logic                         drvalid,
    output logic                         dresp_valid,
    output logic                         derr,
    input  logic [LANE_WIDTH-1:0]        mrdata,
    output logic [LANE_WIDTH-1:0]        mwdata,
    output logic                         mmode,
    output logic                         mvalid,
    input  logic                         svalid,
    output logic                         mbreq,
    input  logic                         mbgrant,
    input  logic                         msplit,
    input  logic                         ack
);
    localparam int SM     = SLAVE_MEM_ADDR_WIDTH;
    localparam int DEV_W  = ADDR_WIDTH - SM;
    localparam int DEV_CH = DEV_W / LANE_WIDTH;
    localparam int MEM_CH = SM / LANE_WIDTH;
    localparam int DAT_CH = DATA_WIDTH / LANE_WIDTH;
    localparam int LW     = $clog2(MAX_BURST) + 1;
    localparam int SW0    = (DEV_W > SM) ? DEV_W : SM;
    localparam int SW     = (SW0 > DATA_WIDTH) ? SW0 : DATA_WIDTH;
    localparam int CW     = $clog2(SW) + 1;
    localparam int TW     = $clog2(TIMEOUT + 1) + 1;
    localparam int RW     = $clog2(MAX_RETRY + 1) + 1;

    typedef enum logic [3:0] {
        IDLE, REQ, SADDR, WAIT, ADDR, WDATA, WFETCH, RDATA, SPLIT, RESP
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  mode_q, mode_d;
    logic [LW-1:0]         len_q, len_d, beat_q, beat_d, dlen_c;
    logic [DATA_WIDTH-1:0] wd_q, wd_d, asm_q, asm_d, drdata_q, drdata_d;
    logic                  drvalid_q, drvalid_d, derr_q, derr_d;
    logic [SW-1:0]         sh_q, sh_d, dev_f, mem_f;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [TW-1:0]         wait_q, wait_d;
    logic [RW-1:0]         retry_q, retry_d;
    logic                  last_beat, adv;

    assign dev_f     = SW'(addr_q[ADDR_WIDTH-1:SM]);
    assign mem_f     = SW'(addr_q[SM-1:0]);
    assign last_beat = (beat_q == len_q - LW'(1));

    assign dready      = (state_q == IDLE);
    assign mbreq       = (state_q != IDLE) && (state_q != RESP);
    assign mvalid      = (state_q == SADDR) || (state_q == ADDR) ||
                         (state_q == WDATA);
    assign dwready     = (state_q == WFETCH);
    assign dresp_valid = (state_q == RESP);
    assign mwdata      = sh_q[LANE_WIDTH-1:0];
    assign mmode       = mode_q;
    assign drdata      = drdata_q;
    assign drvalid     = drvalid_q;
    assign derr        = derr_q;

    always_comb begin
        dlen_c = dlen;
        if (dlen == '0)
            dlen_c = LW'(1);
        else if (dlen > LW'(MAX_BURST))
            dlen_c = LW'(MAX_BURST);
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        mode_d    = mode_q;
        len_d     = len_q;
        beat_d    = beat_q;
        wd_d      = wd_q;
        asm_d     = asm_q;
        drdata_d  = drdata_q;
        drvalid_d = 1'b0;
        derr_d    = derr_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        retry_d   = retry_q;
        adv       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dvalid) begin
                    addr_d  = daddr;
                    mode_d  = dmode;
                    len_d   = dlen_c;
                    wd_d    = dwdata;
                    beat_d  = '0;
                    retry_d = '0;
                    derr_d  = 1'b0;
                    cnt_d   = '0;
                    wait_d  = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mbgrant) begin
                    sh_d    = dev_f;
                    cnt_d   = '0;
                    state_d = SADDR;
                end
            end
            SADDR: begin
                sh_d  = sh_q >> LANE_WIDTH;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DEV_CH - 1)) begin
                    cnt_d   = '0;
                    wait_d  = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                wait_d = wait_q + TW'(1);
                // ack wins over a timeout landing in the same cycle
                if (ack) begin
                    sh_d    = mem_f;
                    cnt_d   = '0;
                    state_d = ADDR;
                end else if (wait_d == TW'(TIMEOUT)) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        wait_d  = '0;
                        sh_d    = dev_f;
                        cnt_d   = '0;
                        state_d = SADDR;
                    end else begin
                        derr_d  = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ADDR: begin
                sh_d  = sh_q >> LANE_WIDTH;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(MEM_CH - 1)) begin
                    cnt_d = '0;
                    if (mode_q) begin
                        sh_d    = SW'(wd_q);
                        state_d = WDATA;
                    end else begin
                        state_d = RDATA;
                    end
                end
            end
            WDATA: begin
                sh_d  = sh_q >> LANE_WIDTH;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DAT_CH - 1)) begin
                    cnt_d   = '0;
                    state_d = last_beat ? RESP : WFETCH;
                end
            end
            WFETCH: begin
                if (dwvalid) begin
                    wd_d = dwnext;
                    adv  = 1'b1;
                end
            end
            RDATA: begin
                if (msplit) begin
                    state_d = SPLIT;
                end else if (svalid) begin
                    asm_d[int'(cnt_q)*LANE_WIDTH +: LANE_WIDTH] = mrdata;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(DAT_CH - 1)) begin
                        drdata_d  = asm_d;
                        drvalid_d = 1'b1;
                        cnt_d     = '0;
                        if (last_beat)
                            state_d = RESP;
                        else
                            adv = 1'b1;
                    end
                end
            end
            SPLIT: begin
                if (!msplit && mbgrant)
                    state_d = RDATA;
            end
            RESP: begin
                state_d = IDLE;
            end
        endcase
        // device field is fixed; memory field wraps inside the same slave
        if (adv) begin
            addr_d[SM-1:0] = addr_q[SM-1:0] + SM'(1);
            beat_d         = beat_q + LW'(1);
            retry_d        = '0;
            sh_d           = dev_f;
            cnt_d          = '0;
            state_d        = SADDR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            mode_q    <= 1'b0;
            len_q     <= '0;
            beat_q    <= '0;
            wd_q      <= '0;
            asm_q     <= '0;
            drdata_q  <= '0;
            drvalid_q <= 1'b0;
            derr_q    <= 1'b0;
            sh_q      <= '0;
            cnt_q     <= '0;
            wait_q    <= '0;
            retry_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            mode_q    <= mode_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            wd_q      <= wd_d;
            asm_q     <= asm_d;
            drdata_q  <= drdata_d;
            drvalid_q <= drvalid_d;
            derr_q    <= derr_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            retry_q   <= retry_d;
        end
    end
endmodule

// File: tb/tb_master_port_burst.sv
// Bench for master_port_burst: vector table plus scoreboard of serial
// chunks, read words and responses, with split/retry/reset sequences.
module tb_master_port_burst;
    localparam int AW     = 16;
    localparam int DW     = 8;
    localparam int SM     = 12;
    localparam int L      = 2;
    localparam int MB     = 8;
    localparam int DEV_CH = (AW - SM) / L;
    localparam int MEM_CH = SM / L;
    localparam int DAT_CH = DW / L;
    localparam int LW     = $clog2(MB) + 1;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic dvalid = 1'b0, dmode = 1'b0, dwvalid = 1'b0, ack = 1'b1;
    logic [AW-1:0] daddr = '0;
    logic [LW-1:0] dlen = '0;
    logic [DW-1:0] dwdata = '0, dwnext = '0;
    logic [L-1:0]  mrdata = '0;
    logic svalid = 1'b0, mbgrant = 1'b1, msplit = 1'b0;
    logic dready, dwready, drvalid, dresp_valid, derr, mmode, mvalid, mbreq;
    logic [DW-1:0] drdata;
    logic [L-1:0]  mwdata;

    master_port_burst #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLAVE_MEM_ADDR_WIDTH(SM),
        .LANE_WIDTH(L), .MAX_BURST(MB), .TIMEOUT(5), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rstn(rstn), .dvalid(dvalid), .dready(dready),
        .daddr(daddr), .dmode(dmode), .dlen(dlen), .dwdata(dwdata),
        .dwvalid(dwvalid), .dwready(dwready), .dwnext(dwnext),
        .drdata(drdata), .drvalid(drvalid), .dresp_valid(dresp_valid),
        .derr(derr), .mrdata(mrdata), .mwdata(mwdata), .mmode(mmode),
        .mvalid(mvalid), .svalid(svalid), .mbreq(mbreq),
        .mbgrant(mbgrant), .msplit(msplit), .ack(ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic          mode;
        logic [LW-1:0] dlen;
        int            nb;
        logic          ack;
        logic          err;
        logic [DW-1:0] w [8];
    } vec_t;

    int total = 0;
    int bad = 0;
    logic [L-1:0]  exp_ch [$];
    logic [DW-1:0] exp_rd [$];
    logic [DW-1:0] sl_q [$];
    logic          exp_resp [$];
    int resp_cnt = 0, rd_cnt = 0, bc = 0;
    logic cur_mode = 1'b0;
    int split_at = -1;
    logic split_done = 1'b0;
    logic in_split = 1'b0;
    int split_bad = 0;
    int split_left = 0;
    logic feeding = 1'b0;
    int fc = 0;
    logic [DW-1:0] cur = '0;

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic void push_f(input logic [15:0] f, input int n);
        for (int i = 0; i < n; i++)
            exp_ch.push_back(L'(f >> (i * L)));
    endfunction

    // slave side: serves read words, injects one split, then monitors
    always @(negedge clk) begin
        svalid = 1'b0;
        if (!rstn) begin
            feeding = 1'b0;
            split_left = 0;
            in_split = 1'b0;
            msplit = 1'b0;
            mbgrant = 1'b1;
            mrdata = '0;
            bc = 0;
        end else begin
            if (split_left > 0) begin
                split_left--;
                if (split_left == 0) begin
                    msplit = 1'b0;
                    mbgrant = 1'b1;
                    in_split = 1'b0;
                end
            end else if (feeding) begin
                if (fc == split_at && !split_done) begin
                    msplit = 1'b1;
                    mbgrant = 1'b0;
                    svalid = 1'b1;
                    mrdata = ~cur[fc*L +: L];
                    split_left = 6;
                    split_done = 1'b1;
                    in_split = 1'b1;
                end else begin
                    svalid = 1'b1;
                    mrdata = cur[fc*L +: L];
                    fc++;
                    if (fc == DAT_CH) feeding = 1'b0;
                end
            end
            if (in_split && mvalid) split_bad++;
            if (mvalid) begin
                if (exp_ch.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL chunk: got %0h expected none", mwdata);
                end else begin
                    chk("chunk", int'(mwdata), int'(exp_ch.pop_front()));
                end
                bc++;
                if (!cur_mode && bc == DEV_CH + MEM_CH) begin
                    bc = 0;
                    feeding = 1'b1;
                    fc = 0;
                    cur = (sl_q.size() > 0) ? sl_q.pop_front() : '0;
                end else if (cur_mode && bc == DEV_CH + MEM_CH + DAT_CH) begin
                    bc = 0;
                end
            end
            if (drvalid) begin
                rd_cnt++;
                if (exp_rd.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL drdata: got %0h expected none", drdata);
                end else begin
                    chk("drdata", int'(drdata), int'(exp_rd.pop_front()));
                end
            end
            if (dresp_valid) begin
                resp_cnt++;
                bc = 0;
                if (exp_resp.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL resp: got pulse expected none");
                end else begin
                    chk("derr", int'(derr), int'(exp_resp.pop_front()));
                end
                chk("mbreq_resp", int'(mbreq), 0);
            end
        end
    end

    task automatic push_beats(input vec_t v);
        logic [AW-1:0] a;
        if (v.err) begin
            for (int t = 0; t < 3; t++) push_f(16'(v.addr >> SM), DEV_CH);
        end else begin
            for (int b = 0; b < v.nb; b++) begin
                a = v.addr;
                a[SM-1:0] = v.addr[SM-1:0] + SM'(b);
                push_f(16'(a >> SM), DEV_CH);
                push_f(16'(a[SM-1:0]), MEM_CH);
                if (v.mode) begin
                    push_f(16'(v.w[b]), DAT_CH);
                end else begin
                    exp_rd.push_back(v.w[b]);
                    sl_q.push_back(v.w[b]);
                end
            end
        end
    endtask

    task automatic send_cmd(input vec_t v);
        @(negedge clk);
        chk("dready_idle", int'(dready), 1);
        dvalid = 1'b1;
        daddr = v.addr;
        dmode = v.mode;
        dlen = v.dlen;
        dwdata = v.w[0];
        @(negedge clk);
        dvalid = 1'b0;
        chk("dready_busy", int'(dready), 0);
        chk("mmode", int'(mmode), int'(v.mode));
    endtask

    task automatic run_vec(input vec_t v, input int dly_beat, input int dly);
        int r0;
        int k;
        cur_mode = v.mode;
        ack = v.ack;
        push_beats(v);
        exp_resp.push_back(v.err);
        r0 = resp_cnt;
        send_cmd(v);
        if (v.mode && !v.err) begin
            for (int b = 1; b < v.nb; b++) begin
                k = 0;
                while (!dwready && k < 500) begin
                    @(negedge clk);
                    k++;
                end
                if (!dwready) begin
                    chk("dwready_timeout", 0, 1);
                    break;
                end
                if (b == dly_beat) begin
                    repeat (dly) begin
                        chk("dwready_hold", int'(dwready), 1);
                        chk("mbreq_hold", int'(mbreq), 1);
                        @(negedge clk);
                    end
                end
                dwvalid = 1'b1;
                dwnext = v.w[b];
                @(negedge clk);
                dwvalid = 1'b0;
            end
        end
        k = 0;
        while (resp_cnt == r0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("resp_seen", resp_cnt - r0, 1);
        chk("chunks_left", exp_ch.size(), 0);
        chk("reads_left", exp_rd.size(), 0);
        ack = 1'b1;
    endtask

    vec_t tv [6];
    vec_t hv;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int d0;
        int k;
        tv[0] = '{16'h1234, 1'b1, 4'd1, 1, 1'b1, 1'b0,
                  '{8'hA5, 0, 0, 0, 0, 0, 0, 0}};
        tv[1] = '{16'h2FFE, 1'b0, 4'd4, 4, 1'b1, 1'b0,
                  '{8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 0, 0}};
        tv[2] = '{16'h3005, 1'b1, 4'd0, 1, 1'b1, 1'b0,
                  '{8'h5A, 0, 0, 0, 0, 0, 0, 0}};
        tv[3] = '{16'h4FFC, 1'b0, 4'd12, 8, 1'b1, 1'b0,
                  '{8'h81, 8'h42, 8'h24, 8'h18, 8'hF0, 8'h0F, 8'hC3, 8'h3C}};
        tv[4] = '{16'h7123, 1'b1, 4'd1, 1, 1'b0, 1'b1,
                  '{8'h77, 0, 0, 0, 0, 0, 0, 0}};
        tv[5] = '{16'h5FFF, 1'b1, 4'd2, 2, 1'b1, 1'b0,
                  '{8'h3C, 8'hC3, 0, 0, 0, 0, 0, 0}};

        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dready", int'(dready), 1);
        chk("rst_mvalid", int'(mvalid), 0);
        chk("rst_mbreq", int'(mbreq), 0);
        chk("rst_mwdata", int'(mwdata), 0);
        chk("rst_dresp", int'(dresp_valid), 0);
        chk("rst_derr", int'(derr), 0);
        chk("rst_dwready", int'(dwready), 0);
        chk("rst_drvalid", int'(drvalid), 0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(tv[i], -1, 0);

        hv = '{16'h1ABC, 1'b0, 4'd1, 1, 1'b1, 1'b0,
               '{8'h96, 0, 0, 0, 0, 0, 0, 0}};
        split_at = 2;
        run_vec(hv, -1, 0);
        chk("split_seen", int'(split_done), 1);
        chk("mvalid_in_split", split_bad, 0);

        hv = '{16'h8010, 1'b1, 4'd3, 3, 1'b1, 1'b0,
               '{8'h01, 8'h80, 8'hFE, 0, 0, 0, 0, 0}};
        run_vec(hv, 1, 10);

        hv = '{16'h9000, 1'b0, 4'd4, 4, 1'b1, 1'b0,
               '{8'h5A, 8'hA5, 8'h3C, 8'hC3, 0, 0, 0, 0}};
        cur_mode = 1'b0;
        push_beats(hv);
        r0 = resp_cnt;
        d0 = rd_cnt;
        send_cmd(hv);
        k = 0;
        while (rd_cnt < d0 + 2 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("beats_before_reset", rd_cnt - d0, 2);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("mid_dready", int'(dready), 1);
        chk("mid_mvalid", int'(mvalid), 0);
        chk("mid_mbreq", int'(mbreq), 0);
        chk("mid_mwdata", int'(mwdata), 0);
        chk("mid_mmode", int'(mmode), 0);
        chk("mid_drdata", int'(drdata), 0);
        chk("mid_drvalid", int'(drvalid), 0);
        chk("mid_dresp", int'(dresp_valid), 0);
        chk("mid_derr", int'(derr), 0);
        chk("mid_dwready", int'(dwready), 0);
        exp_ch.delete();
        exp_rd.delete();
        sl_q.delete();
        exp_resp.delete();
        @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_resp_after_reset", resp_cnt - r0, 0);

        run_vec(tv[0], -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
